// File: rtl/seq_detect_pkg.sv
// Shared types and next-state function for the time-shared Mealy "011" detector.
// Pure definitions only; no clocked logic lives here.
package seq_detect_pkg;

    typedef logic [1:0] st_t;

    localparam logic [1:0] ST_A = 2'b00;  // idle
    localparam logic [1:0] ST_B = 2'b01;  // seen 0
    localparam logic [1:0] ST_C = 2'b10;  // seen 01

    typedef struct packed {
        logic hit;
        st_t  nxt;
    } step_t;

    function automatic step_t det_step(input st_t s, input logic x);
        step_t r;
        r.hit = 1'b0;
        r.nxt = ST_A;
        case (s)
            ST_A: r.nxt = x ? ST_A : ST_B;
            ST_B: r.nxt = x ? ST_C : ST_B;
            ST_C: begin
                r.nxt = x ? ST_A : ST_B;
                r.hit = x;
            end
            default: r.nxt = ST_A;  // illegal 2'b11 recovers silently
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester/monitor bundle for seq_detect_scheduler; sel_count exists only
// when SEQ_DETECT_HIT_COUNT_EN is defined.
interface seq_detect_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] ack;
    logic            y;
    logic [CH_W-1:0] y_ch;
    logic [CH_W-1:0] sel_ch;
    logic [1:0]      sel_state;

    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

`ifdef SEQ_DETECT_HIT_COUNT_EN
    logic [CNT_W-1:0] sel_count;

    modport master (output req, x, clr, sel_ch,
                    input  ack, y, y_ch, sel_state, sel_count);
    modport slave  (input  req, x, clr, sel_ch,
                    output ack, y, y_ch, sel_state, sel_count);
`else
    modport master (output req, x, clr, sel_ch,
                    input  ack, y, y_ch, sel_state);
    modport slave  (input  req, x, clr, sel_ch,
                    output ack, y, y_ch, sel_state);
`endif

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Purpose: round-robin one-hot grant starting the search at ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; non-eligible requesters simply wait for a later grant.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);

    logic [W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Purpose: one "011" Mealy detector time-shared over N_CH contexts (opt. SEQ_DETECT_HIT_COUNT_EN).
// Latency: ack combinational; y/y_ch registered, one cycle after the granted bit.
// Backpressure: ungranted or cleared channels must hold req/x until ack.
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_detect_scheduler_if.slave  bus
);

    localparam int CH_W = $clog2(N_CH);

    if (N_CH < 2 || N_CH > 16 || CNT_W < 1) begin : g_bad_param
        $error("N_CH must be 2..16 and CNT_W at least 1");
    end

    st_t             ctx [N_CH];
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gnt_idx;
    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] gnt;
    logic            gnt_vld;
    step_t           stp;
    logic            y_q;
    logic [CH_W-1:0] y_ch_q;

    // Holding eligibility low during reset keeps ack quiet without touching the arbiter.
    assign elig = reset ? '0 : (bus.req & ~bus.clr);

    rr_arbiter #(.N(N_CH)) u_arb (
        .elig    (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.ack  = gnt;
    assign stp      = det_step(ctx[gnt_idx], bus.x[gnt_idx]);
    assign bus.y    = y_q;
    assign bus.y_ch = y_ch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) ctx[i] <= ST_A;
            ptr    <= '0;
            y_q    <= 1'b0;
            y_ch_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clr[i])
                    ctx[i] <= ST_A;
                else if (gnt_vld && gnt_idx == CH_W'(i))
                    ctx[i] <= stp.nxt;
            end
            y_q <= gnt_vld & stp.hit;
            if (gnt_vld) begin
                y_ch_q <= gnt_idx;
                ptr    <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_comb begin
        bus.sel_state = ST_A;
        for (int i = 0; i < N_CH; i++)
            if (bus.sel_ch == CH_W'(i)) bus.sel_state = ctx[i];
    end

`ifdef SEQ_DETECT_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt [N_CH];

    // clr has priority over a same-cycle hit; counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clr[i])
                    cnt[i] <= '0;
                else if (gnt_vld && gnt_idx == CH_W'(i) && stp.hit && cnt[i] != '1)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        bus.sel_count = '0;
        for (int i = 0; i < N_CH; i++)
            if (bus.sel_ch == CH_W'(i)) bus.sel_count = cnt[i];
    end
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: vector table, directed corner sequences and
// random traffic against a bit-history reference model.
`timescale 1ns/1ps
module tb_seq_detect_scheduler;

    localparam int N  = 4;
    localparam int CW = 2;
`ifdef SEQ_DETECT_HIT_COUNT_EN
    localparam int CNTW = 2;
`else
    localparam int CNTW = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler_if #(.N_CH(N), .CNT_W(CNTW)) bus ();

    seq_detect_scheduler #(.N_CH(N), .CNT_W(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: bits consumed since the last hit/clear/reset.
    bit hq [N][$];
    int m_ptr, m_ych, m_cnt [N];
    bit m_y;

    function automatic int mstate(input int i);
        int n = hq[i].size();
        if (n >= 2 && hq[i][n-2] == 1'b0 && hq[i][n-1] == 1'b1) return 2;
        if (n >= 1 && hq[i][n-1] == 1'b0) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hq[i].delete();
            m_cnt[i] = 0;
        end
        m_ptr = 0; m_y = 0; m_ych = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ctx_all();
        for (int i = 0; i < N; i++) begin
            bus.sel_ch = CW'(i);
            #0.2;
            chk($sformatf("sel_state[%0d]", i), 32'(bus.sel_state), 32'(mstate(i)));
`ifdef SEQ_DETECT_HIT_COUNT_EN
            chk($sformatf("sel_count[%0d]", i), 32'(bus.sel_count), 32'(m_cnt[i]));
`endif
        end
    endtask

    // Starts shortly after a rising edge, ends 1ns after the next one.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] xx, input logic [N-1:0] cc,
                        output logic [N-1:0] a_ack, output logic a_y);
        int g = -1;
        bit hit = 0;
        bus.req = r; bus.x = xx; bus.clr = cc;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (g < 0 && r[idx] && !cc[idx]) g = idx;
        end
        a_ack = bus.ack;
        chk("ack", 32'(bus.ack), (g >= 0) ? (32'd1 << g) : 32'd0);
        for (int i = 0; i < N; i++)
            if (cc[i]) begin hq[i].delete(); m_cnt[i] = 0; end
        if (g >= 0) begin
            int n;
            hq[g].push_back(xx[g]);
            n = hq[g].size();
            hit = (n >= 3 && hq[g][n-3] == 0 && hq[g][n-2] == 1 && hq[g][n-1] == 1);
            if (hit) begin
                hq[g].delete();
                if (m_cnt[g] < (1 << CNTW) - 1) m_cnt[g]++;
            end
            while (hq[g].size() > 3) void'(hq[g].pop_front());
            m_ych = g;
            m_ptr = (g + 1) % N;
        end
        m_y = hit;
        @(posedge clk);
        #1;
        a_y = bus.y;
        chk("y", 32'(bus.y), 32'(m_y));
        chk("y_ch", 32'(bus.y_ch), 32'(m_ych));
    endtask

    // Reset asserted between edges; everything must clear immediately.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        bus.req = '1; bus.x = '1; bus.clr = '0;
        model_reset();
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_y_ch", 32'(bus.y_ch), 32'd0);
        chk_ctx_all();
        bus.req = '0; bus.x = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req, x, clr, ack;
        logic       y;
    } vec_t;

    vec_t tbl [15];
    logic [N-1:0] a_ack;
    logic a_y;
    int pulses, pulse_ch;

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.x = '0; bus.clr = '0; bus.sel_ch = '0;
        model_reset();

        tbl[0]  = '{1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[1]  = '{0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[2]  = '{0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
        tbl[3]  = '{1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[4]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[5]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[6]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[7]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[8]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[9]  = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[10] = '{0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[11] = '{0, 4'b1101, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[12] = '{0, 4'b1101, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[13] = '{0, 4'b1101, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[14] = '{0, 4'b1101, 4'b0000, 4'b0000, 4'b0001, 1'b0};

        @(posedge clk);
        #1;
        for (int r = 0; r < 15; r++) begin
            if (tbl[r].rst) do_reset();
            step(tbl[r].req, tbl[r].x, tbl[r].clr, a_ack, a_y);
            chk($sformatf("tbl%0d_ack", r), 32'(a_ack), 32'(tbl[r].ack));
            chk($sformatf("tbl%0d_y", r), 32'(a_y), 32'(tbl[r].y));
            if (r == 2) chk_ctx_all();
        end

        // Interleaved: ch1 sends 0,1,1 and ch2 sends 1,1,1 on alternating grants.
        do_reset();
        pulses = 0; pulse_ch = -1;
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] xv;
            xv = '0;
            xv[1] = (k / 2) != 0;
            xv[2] = 1'b1;
            step(4'b0110, xv, 4'b0000, a_ack, a_y);
            if (a_y) begin pulses++; pulse_ch = int'(bus.y_ch); end
        end
        chk("interleave_pulses", 32'(pulses), 32'd1);
        chk("interleave_ych", 32'(pulse_ch), 32'd1);
        chk_ctx_all();

        // clr collides with a would-be hit on ch3; ptr must stay put.
        do_reset();
        step(4'b1000, 4'b0000, 4'b0000, a_ack, a_y);
        step(4'b1000, 4'b1000, 4'b0000, a_ack, a_y);
        chk_ctx_all();
        step(4'b1000, 4'b1000, 4'b1000, a_ack, a_y);
        chk("clr_ack", 32'(a_ack), 32'd0);
        chk("clr_y", 32'(a_y), 32'd0);
        chk_ctx_all();
        step(4'b1111, 4'b0000, 4'b0000, a_ack, a_y);
        chk("clr_ptr_ack", 32'(a_ack), 32'b0001);

        // Async reset while ch0 sits in C; a following 1 must not hit.
        do_reset();
        step(4'b0001, 4'b0000, 4'b0000, a_ack, a_y);
        step(4'b0001, 4'b0001, 4'b0000, a_ack, a_y);
        do_reset();
        step(4'b0001, 4'b0001, 4'b0000, a_ack, a_y);
        chk("post_rst_y", 32'(a_y), 32'd0);

`ifdef SEQ_DETECT_HIT_COUNT_EN
        do_reset();
        for (int h = 0; h < 15; h++)
            step(4'b0001, (h % 3 == 0) ? 4'b0000 : 4'b0001, 4'b0000, a_ack, a_y);
        bus.sel_ch = '0;
        #0.2;
        chk("cnt_sat", 32'(bus.sel_count), 32'd3);
        step(4'b0000, 4'b0000, 4'b0001, a_ack, a_y);
        bus.sel_ch = '0;
        #0.2;
        chk("cnt_clr", 32'(bus.sel_count), 32'd0);
`endif

        // Random traffic with occasional clears and mid-stream resets.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] rr, xr, cr;
            rr = N'($urandom);
            xr = N'($urandom);
            cr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            step(rr, xr, cr, a_ack, a_y);
            if (c % 25 == 24) chk_ctx_all();
            if (c % 150 == 149) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
